fetch_if_id_stage: RTL and testbench
====================================

Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register of the dynamic MIPS pipeline.
- Holds the PC, drives the instruction-memory address, and latches the fetched word into ID.
- Consumes the load-use `stall` from the data-hazard detector and the branch/jump redirect resolved in ID.
- Inserts bubbles and squashes wrong-path fetches, so downstream stages see a clean stream.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, encoding driven into ID for a bubble or squashed slot.
- CNT_W, 32, width of the stall and squash performance counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; freeze PC and IF/ID this cycle.
- redirect  input  1  taken branch/jump resolved in ID this cycle.
- redirect_pc  input  32  target address accompanying redirect.
- imem_addr  output  32  instruction-memory address (= pc, combinational).
- imem_rdata  input  32  instruction word for imem_addr, valid in the same cycle (asynchronous ROM).
- pc  output  32  current fetch PC.
- id_inst  output  32  instruction held in ID.
- id_pc  output  32  PC of id_inst.
- id_pc4  output  32  id_pc + 4.
- id_valid  output  1  1 = id_inst is a real instruction; 0 = bubble/squash.
- stall_cnt  output  CNT_W  cycles with stall=1 since reset.
- squash_cnt  output  CNT_W  redirects honoured since reset.

Behaviour:
- Reset values:
  - pc = RESET_PC.
  - id_inst = NOP_INST, id_pc = 0, id_pc4 = 4, id_valid = 0.
  - stall_cnt = 0, squash_cnt = 0.
- rst dominates every other input on the same edge. Reset asserted mid-stall or mid-redirect discards all state.
- No branch delay slot. The instruction fetched in the cycle a redirect is honoured is wrong-path and is squashed.
- Per-edge priority when rst=0:
  1. stall=1:
     - pc, id_inst, id_pc, id_pc4, id_valid hold their values.
     - redirect is ignored, because the branch in ID may itself be waiting on operands. ID re-asserts redirect once the stall drops.
     - stall_cnt increments.
  2. stall=0, redirect=1:
     - pc <= redirect_pc.
     - id_inst <= NOP_INST, id_valid <= 0, id_pc <= pc, id_pc4 <= pc + 4.
     - squash_cnt increments.
  3. stall=0, redirect=0:
     - pc <= pc + 4.
     - id_inst <= imem_rdata, id_pc <= pc, id_pc4 <= pc + 4, id_valid <= 1.
- Latency: an instruction at address A appears in ID one edge after pc = A, provided stall is not asserted on that edge.
- Arithmetic:
  - PC increment is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
  - redirect_pc is taken verbatim; low bits are not forced to 0.
- Counters saturate at all-ones; they never wrap.
- Internal state machine, 2 states, visible only through the outputs:
  - RUN: normal operation.
  - HOLD: entered on any edge with stall=1; exits to RUN on the first edge with stall=0.
  - Its only required effect: imem_addr stays stable throughout a stall, so the ROM word in ID is unchanged on release.
- Back-to-back redirects (stall=0 on both edges): each is honoured. Two consecutive bubbles appear, and pc follows the second target.
- stall and redirect are sampled only at the clock edge; glitches between edges are irrelevant.

Test Plan:
1. Reset then free-run, ROM word = address: after rst drops, ID shows id_pc = 32'h0040_0000, 32'h0040_0004, 32'h0040_0008 on successive edges, each with id_valid = 1 and id_inst equal to its id_pc.
2. Load-use stall: assert stall for 2 cycles while ID holds 32'h0040_0008.
   - id_inst, id_pc and pc are frozen for 2 edges; stall_cnt = 2.
   - On release, ID advances to 32'h0040_000C.
3. Redirect, stall=0, redirect_pc = 32'h0040_0100:
   - Next edge: id_valid = 0 and id_inst = NOP_INST; pc = 32'h0040_0100.
   - Following edge: id_pc = 32'h0040_0100 with id_valid = 1; squash_cnt = 1.
4. Stall and redirect together for one cycle, then redirect alone:
   - First edge: nothing changes; squash_cnt stays 0.
   - Second edge: redirect is taken; squash_cnt = 1.
5. Reset mid-stall: stall = 1 held while rst pulses. Next edge gives pc = RESET_PC, id_valid = 0, and both counters = 0.
6. PC wrap: redirect to 32'hFFFF_FFFC, then free-run. Fetch order is 32'hFFFF_FFFC, then 32'h0000_0000, with no X on any output.

Source files
------------

// File: rtl/fetch_if_id_stage.sv
// rtl/fetch_if_id_stage.sv - instruction fetch stage and IF/ID pipeline register
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      hold_addr_q, hold_addr_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_pc4_q, id_pc4_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = stall ? ST_HOLD : ST_RUN;
        // The address seen by the ROM is pinned on stall entry so the word
        // presented on release is the one that was fetched before the freeze.
        hold_addr_d  = (state_q == ST_RUN) ? pc_q : hold_addr_q;
        pc_d         = pc_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_valid_d   = id_valid_q;
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;

        if (stall) begin
            // Redirect is ignored here: the branch in ID may still be waiting on operands.
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
        end else if (redirect) begin
            pc_d         = redirect_pc;
            id_inst_d    = NOP_INST;
            id_valid_d   = 1'b0;
            id_pc_d      = pc_q;
            id_pc4_d     = pc_plus4;
            squash_cnt_d = (&squash_cnt_q) ? squash_cnt_q : squash_cnt_q + CNT_ONE;
        end else begin
            pc_d       = pc_plus4;
            id_inst_d  = imem_rdata;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            hold_addr_q  <= RESET_PC;
            id_inst_q    <= NOP_INST;
            id_pc_q      <= 32'h0000_0000;
            id_pc4_q     <= 32'h0000_0004;
            id_valid_q   <= 1'b0;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_addr_q  <= hold_addr_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_valid_q   <= id_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign imem_addr  = (state_q == ST_HOLD) ? hold_addr_q : pc_q;
    assign pc         = pc_q;
    assign id_inst    = id_inst_q;
    assign id_pc      = id_pc_q;
    assign id_pc4     = id_pc4_q;
    assign id_valid   = id_valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// tb/tb_fetch_if_id_stage.sv - self-checking bench for fetch_if_id_stage
module tb_fetch_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] rom_key = 32'h0;

    logic [31:0] imem_addr, imem_rdata, pc, id_inst, id_pc, id_pc4;
    logic        id_valid;
    logic [31:0] stall_cnt, squash_cnt;

    logic [31:0] imem_addr_s, imem_rdata_s, pc_s, id_inst_s, id_pc_s, id_pc4_s;
    logic        id_valid_s;
    logic [2:0]  stall_cnt_s, squash_cnt_s;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_id_inst, m_id_pc;
    logic        m_id_valid;
    longint      m_stalls, m_squashes;

    always #5 clk = ~clk;

    assign imem_rdata   = imem_addr ^ rom_key;
    assign imem_rdata_s = imem_addr_s ^ rom_key;

    fetch_if_id_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .id_inst(id_inst),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
        .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
    );

    fetch_if_id_stage #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s), .pc(pc_s), .id_inst(id_inst_s),
        .id_pc(id_pc_s), .id_pc4(id_pc4_s), .id_valid(id_valid_s),
        .stall_cnt(stall_cnt_s), .squash_cnt(squash_cnt_s)
    );

    function automatic logic [2:0] sat3(input longint n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_id_inst = NOP_INST; m_id_pc = 32'h0; m_id_valid = 1'b0;
            m_stalls = 0; m_squashes = 0;
        end else if (s) begin
            m_stalls++;
        end else if (rd) begin
            m_id_pc = m_pc; m_id_inst = NOP_INST; m_id_valid = 1'b0; m_pc = rpc; m_squashes++;
        end else begin
            m_id_pc = m_pc; m_id_inst = m_pc ^ rom_key; m_id_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
        #1;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_reset;
        rom_key = 32'h0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h1234_5678);
        n_vec++; if (pc !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        n_vec++; if (id_inst !== NOP_INST) begin n_err++; $display("FAIL reset_id_inst: got %h want %h", id_inst, NOP_INST); end
        n_vec++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        n_vec++; if (id_pc4 !== 32'h4) begin n_err++; $display("FAIL reset_id_pc4: got %h want 4", id_pc4); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        n_vec++; if (stall_cnt !== 32'h0 || squash_cnt !== 32'h0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, squash_cnt); end
        n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_free_run;
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = RESET_PC + 32'(4 * i);
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (id_pc !== exp_pc || id_inst !== exp_pc || id_valid !== 1'b1) begin
                n_err++; $display("FAIL free_run_%0d: got pc=%h inst=%h v=%b want %h/%h/1", i, id_pc, id_inst, id_valid, exp_pc, exp_pc);
            end
            n_vec++; if (id_pc4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL free_run_pc4_%0d: got %h want %h", i, id_pc4, exp_pc + 32'd4); end
        end
    endtask

    task automatic test_load_use_stall;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            n_vec++; if (id_pc !== 32'h0040_0008 || id_inst !== 32'h0040_0008 || pc !== 32'h0040_000C) begin
                n_err++; $display("FAIL stall_freeze_%0d: got id_pc=%h inst=%h pc=%h want 00400008/00400008/0040000c", i, id_pc, id_inst, pc);
            end
            n_vec++; if (imem_addr !== 32'h0040_000C) begin n_err++; $display("FAIL stall_imem_addr_%0d: got %h want 0040000c", i, imem_addr); end
        end
        n_vec++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_pc !== 32'h0040_000C || id_inst !== 32'h0040_000C || id_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_release: got id_pc=%h inst=%h v=%b want 0040000c/0040000c/1", id_pc, id_inst, id_valid);
        end
    endtask

    task automatic test_redirect;
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        n_vec++; if (id_valid !== 1'b0 || id_inst !== NOP_INST || pc !== 32'h0040_0100) begin
            n_err++; $display("FAIL redirect_bubble: got v=%b inst=%h pc=%h want 0/%h/00400100", id_valid, id_inst, pc, NOP_INST);
        end
        n_vec++; if (id_pc !== 32'h0040_0010) begin n_err++; $display("FAIL redirect_squashed_pc: got %h want 00400010", id_pc); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_pc !== 32'h0040_0100 || id_valid !== 1'b1) begin n_err++; $display("FAIL redirect_target: got %h v=%b want 00400100/1", id_pc, id_valid); end
        n_vec++; if (squash_cnt !== 32'd1) begin n_err++; $display("FAIL redirect_squash_cnt: got %0d want 1", squash_cnt); end
    endtask

    task automatic test_stall_with_redirect;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0040_0200);
        n_vec++; if (pc !== RESET_PC || id_valid !== 1'b0 || squash_cnt !== 32'd0) begin
            n_err++; $display("FAIL stall_redirect_hold: got pc=%h v=%b sq=%0d want %h/0/0", pc, id_valid, squash_cnt, RESET_PC);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0200);
        n_vec++; if (pc !== 32'h0040_0200 || squash_cnt !== 32'd1 || id_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_redirect_take: got pc=%h sq=%0d v=%b want 00400200/1/0", pc, squash_cnt, id_valid);
        end
    endtask

    task automatic test_reset_mid_stall;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        n_vec++; if (pc !== RESET_PC || id_valid !== 1'b0 || stall_cnt !== 32'd0 || squash_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_mid_stall: got pc=%h v=%b st=%0d sq=%0d want %h/0/0/0", pc, id_valid, stall_cnt, squash_cnt, RESET_PC);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_pc !== RESET_PC || id_valid !== 1'b1) begin n_err++; $display("FAIL reset_mid_stall_restart: got %h v=%b want %h/1", id_pc, id_valid, RESET_PC); end
    endtask

    task automatic test_pc_wrap;
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_pc !== 32'hFFFF_FFFC || id_inst !== 32'hFFFF_FFFC || pc !== 32'h0) begin
            n_err++; $display("FAIL wrap_first: got id_pc=%h inst=%h pc=%h want fffffffc/fffffffc/0", id_pc, id_inst, pc);
        end
        n_vec++; if (id_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want 0", id_pc4); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_pc !== 32'h0 || id_valid !== 1'b1 || pc !== 32'h4) begin n_err++; $display("FAIL wrap_second: got id_pc=%h v=%b pc=%h want 0/1/4", id_pc, id_valid, pc); end
        n_vec++; if ($isunknown({imem_addr, pc, id_inst, id_pc, id_pc4, id_valid, stall_cnt, squash_cnt})) begin
            n_err++; $display("FAIL wrap_no_x: got X on outputs pc=%h id_pc=%h want known", pc, id_pc);
        end
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_2003);
        n_vec++; if (id_valid !== 1'b0 || pc !== 32'h0000_2003) begin n_err++; $display("FAIL b2b_first: got v=%b pc=%h want 0/00002003", id_valid, pc); end
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_3000);
        n_vec++; if (id_valid !== 1'b0 || id_pc !== 32'h0000_2003 || pc !== 32'h0000_3000) begin
            n_err++; $display("FAIL b2b_second: got v=%b id_pc=%h pc=%h want 0/00002003/00003000", id_valid, id_pc, pc);
        end
        n_vec++; if (squash_cnt !== 32'd2) begin n_err++; $display("FAIL b2b_squash_cnt: got %0d want 2", squash_cnt); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_pc !== 32'h0000_3000 || id_valid !== 1'b1) begin n_err++; $display("FAIL b2b_target: got %h v=%b want 00003000/1", id_pc, id_valid); end
    endtask

    task automatic test_counter_saturation;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100 + 32'(i * 8));
        n_vec++; if (stall_cnt_s !== 3'd7 || squash_cnt_s !== 3'd7) begin
            n_err++; $display("FAIL sat_small: got %0d/%0d want 7/7", stall_cnt_s, squash_cnt_s);
        end
        n_vec++; if (stall_cnt !== 32'd10 || squash_cnt !== 32'd9) begin
            n_err++; $display("FAIL sat_wide: got %0d/%0d want 10/9", stall_cnt, squash_cnt);
        end
    endtask

    task automatic test_random;
        logic        r, s, rd;
        logic [31:0] rpc;
        rom_key = $urandom();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 3) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
            cycle(r, s, rd, rpc);
            n_vec++; if (pc !== m_pc || imem_addr !== m_pc) begin n_err++; $display("FAIL rand_pc[%0d]: got %h/%h want %h", i, pc, imem_addr, m_pc); end
            n_vec++; if (id_inst !== m_id_inst) begin n_err++; $display("FAIL rand_id_inst[%0d]: got %h want %h", i, id_inst, m_id_inst); end
            n_vec++; if (id_pc !== m_id_pc || id_pc4 !== m_id_pc + 32'd4) begin n_err++; $display("FAIL rand_id_pc[%0d]: got %h/%h want %h/%h", i, id_pc, id_pc4, m_id_pc, m_id_pc + 32'd4); end
            n_vec++; if (id_valid !== m_id_valid) begin n_err++; $display("FAIL rand_id_valid[%0d]: got %b want %b", i, id_valid, m_id_valid); end
            n_vec++; if (stall_cnt !== 32'(m_stalls) || squash_cnt !== 32'(m_squashes)) begin
                n_err++; $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, squash_cnt, m_stalls, m_squashes);
            end
            n_vec++; if (stall_cnt_s !== sat3(m_stalls) || squash_cnt_s !== sat3(m_squashes)) begin
                n_err++; $display("FAIL rand_sat_counters[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt_s, squash_cnt_s, sat3(m_stalls), sat3(m_squashes));
            end
        end
    endtask

    initial begin
        m_pc = RESET_PC; m_id_inst = NOP_INST; m_id_pc = 32'h0; m_id_valid = 1'b0;
        m_stalls = 0; m_squashes = 0;
        test_reset;
        test_free_run;
        test_load_use_stall;
        test_redirect;
        test_stall_with_redirect;
        test_reset_mid_stall;
        test_pc_wrap;
        test_back_to_back;
        test_counter_saturation;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
